// File: rtl/rgb_mosaicing.sv
// RGB to raw Bayer mosaicing: keeps the CFA-selected colour component of each pixel.
// Registered skid buffer on the input and a registered output stage cut timing in both directions.
`timescale 1ns/1ps

module rgb_mosaicing #(
    parameter int RAW_PX_WIDTH  = 10,
    parameter int MAX_LINE_SIZE = 1920,
    localparam int RGB_TDATA_WIDTH = ((3 * RAW_PX_WIDTH + 7) / 8) * 8,
    localparam int RAW_TDATA_WIDTH = ((RAW_PX_WIDTH + 7) / 8) * 8,
    localparam int COL_W           = $clog2(MAX_LINE_SIZE + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [1:0]                   pattern_i,
    input  logic                         en_i,
    input  logic                         err_clr_i,
    output logic                         line_len_err_o,
    input  logic [RGB_TDATA_WIDTH-1:0]   rgb_video_i_tdata,
    input  logic                         rgb_video_i_tvalid,
    output logic                         rgb_video_i_tready,
    input  logic                         rgb_video_i_tuser,
    input  logic                         rgb_video_i_tlast,
    output logic [RAW_TDATA_WIDTH-1:0]   raw_video_o_tdata,
    output logic [RAW_TDATA_WIDTH/8-1:0] raw_video_o_tkeep,
    output logic [RAW_TDATA_WIDTH/8-1:0] raw_video_o_tstrb,
    output logic                         raw_video_o_tid,
    output logic                         raw_video_o_tdest,
    output logic                         raw_video_o_tvalid,
    input  logic                         raw_video_o_tready,
    output logic                         raw_video_o_tuser,
    output logic                         raw_video_o_tlast
);

    logic [RAW_PX_WIDTH-1:0] in_r, in_g, in_b, px;
    logic [1:0]              pat_q, pat_eff, pos;
    logic                    en_q, en_eff, row_odd_q, col_odd_q, row_eff, col_eff;
    logic [COL_W-1:0]        col_cnt_q, col_cnt_eff;
    logic                    fire, tready_q, err_q;

    logic [RAW_PX_WIDTH-1:0] skid_px, out_px;
    logic                    skid_user, skid_last, skid_vld;
    logic                    out_user, out_last, out_vld;
    logic                    load_out, skid_vld_nxt;

    generate
        if (RGB_TDATA_WIDTH > 3 * RAW_PX_WIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^rgb_video_i_tdata[RGB_TDATA_WIDTH-1:3*RAW_PX_WIDTH];
        end
    endgenerate

    // A tuser beat is position (0,0) and already uses the pattern/enable being latched on it.
    always_comb begin
        in_g        = rgb_video_i_tdata[RAW_PX_WIDTH-1:0];
        in_b        = rgb_video_i_tdata[2*RAW_PX_WIDTH-1 -: RAW_PX_WIDTH];
        in_r        = rgb_video_i_tdata[3*RAW_PX_WIDTH-1 -: RAW_PX_WIDTH];
        fire        = rgb_video_i_tvalid && tready_q;
        pat_eff     = rgb_video_i_tuser ? pattern_i : pat_q;
        en_eff      = rgb_video_i_tuser ? en_i : en_q;
        row_eff     = rgb_video_i_tuser ? 1'b0 : row_odd_q;
        col_eff     = rgb_video_i_tuser ? 1'b0 : col_odd_q;
        col_cnt_eff = rgb_video_i_tuser ? '0 : col_cnt_q;
        pos         = {row_eff, col_eff};
        px          = in_g;
        if (en_eff) begin
            case (pat_eff)
                2'b00:   px = (pos == 2'b01) ? in_b : (pos == 2'b10) ? in_r : in_g;
                2'b01:   px = (pos == 2'b00) ? in_b : (pos == 2'b11) ? in_r : in_g;
                2'b10:   px = (pos == 2'b01) ? in_r : (pos == 2'b10) ? in_b : in_g;
                default: px = (pos == 2'b00) ? in_r : (pos == 2'b11) ? in_b : in_g;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pat_q     <= '0;
            en_q      <= 1'b0;
            row_odd_q <= 1'b0;
            col_odd_q <= 1'b0;
            col_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (fire) begin
                if (rgb_video_i_tuser) begin
                    pat_q <= pattern_i;
                    en_q  <= en_i;
                end
                if (rgb_video_i_tlast) begin
                    col_odd_q <= 1'b0;
                    row_odd_q <= !row_eff;
                    col_cnt_q <= '0;
                end else begin
                    col_odd_q <= !col_eff;
                    row_odd_q <= row_eff;
                    col_cnt_q <= (col_cnt_eff == COL_W'(MAX_LINE_SIZE)) ? col_cnt_eff
                                                                        : col_cnt_eff + COL_W'(1);
                end
            end
            if (fire && !rgb_video_i_tlast && (col_cnt_eff == COL_W'(MAX_LINE_SIZE)))
                err_q <= 1'b1;
            else if (err_clr_i)
                err_q <= 1'b0;
        end
    end

    // Skid entry can only be occupied while the input is stalled, so fire and skid_vld never coincide.
    always_comb begin
        load_out     = !out_vld || raw_video_o_tready;
        skid_vld_nxt = load_out ? 1'b0 : (skid_vld || fire);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_px   <= '0;
            skid_user <= 1'b0;
            skid_last <= 1'b0;
            skid_vld  <= 1'b0;
            out_px    <= '0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
            out_vld   <= 1'b0;
            tready_q  <= 1'b0;
        end else begin
            skid_vld <= skid_vld_nxt;
            tready_q <= !skid_vld_nxt;
            if (load_out) begin
                if (skid_vld) begin
                    out_px   <= skid_px;
                    out_user <= skid_user;
                    out_last <= skid_last;
                    out_vld  <= 1'b1;
                end else if (fire) begin
                    out_px   <= px;
                    out_user <= rgb_video_i_tuser;
                    out_last <= rgb_video_i_tlast;
                    out_vld  <= 1'b1;
                end else begin
                    out_vld  <= 1'b0;
                end
            end else if (fire) begin
                skid_px   <= px;
                skid_user <= rgb_video_i_tuser;
                skid_last <= rgb_video_i_tlast;
            end
        end
    end

    always_comb begin
        rgb_video_i_tready = tready_q;
        line_len_err_o     = err_q;
        raw_video_o_tdata  = RAW_TDATA_WIDTH'(out_px);
        raw_video_o_tkeep  = '1;
        raw_video_o_tstrb  = '1;
        raw_video_o_tid    = 1'b0;
        raw_video_o_tdest  = 1'b0;
        raw_video_o_tvalid = out_vld;
        raw_video_o_tuser  = out_user;
        raw_video_o_tlast  = out_last;
    end

endmodule

// File: tb/tb_rgb_mosaicing.sv
// Scoreboard bench for rgb_mosaicing: directed frames queue expected raw pixels, a monitor pops on each output beat.
`timescale 1ns/1ps

module tb_rgb_mosaicing;

    localparam int RAW  = 10;
    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pattern;
    logic        en, err_clr, err;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep, m_tstrb;
    logic        m_tid, m_tdest, m_tvalid, m_tready, m_tuser, m_tlast;

    typedef struct {
        logic [9:0] px;
        logic       user;
        logic       last;
        logic       chk_lat;
        int         acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic rand_valid = 1'b0;
    logic rand_ready = 1'b0;
    logic ready_level = 1'b1;
    logic [9:0] r, g, b;

    logic [9:0] t1  [8] = '{10'h3FF, 10'h155, 10'h3FF, 10'h155, 10'h155, 10'h0AA, 10'h155, 10'h0AA};
    logic [9:0] t2  [4][4] = '{'{2, 3, 1, 2}, '{3, 2, 2, 1}, '{2, 1, 3, 2}, '{1, 2, 2, 3}};
    logic [9:0] t4a [8] = '{1, 2, 1, 2, 2, 3, 2, 3};
    logic [9:0] t4b [8] = '{3, 2, 3, 2, 2, 1, 2, 1};

    rgb_mosaicing #(.RAW_PX_WIDTH(RAW), .MAX_LINE_SIZE(MAXL)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .pattern_i          (pattern),
        .en_i               (en),
        .err_clr_i          (err_clr),
        .line_len_err_o     (err),
        .rgb_video_i_tdata  (s_tdata),
        .rgb_video_i_tvalid (s_tvalid),
        .rgb_video_i_tready (s_tready),
        .rgb_video_i_tuser  (s_tuser),
        .rgb_video_i_tlast  (s_tlast),
        .raw_video_o_tdata  (m_tdata),
        .raw_video_o_tkeep  (m_tkeep),
        .raw_video_o_tstrb  (m_tstrb),
        .raw_video_o_tid    (m_tid),
        .raw_video_o_tdest  (m_tdest),
        .raw_video_o_tvalid (m_tvalid),
        .raw_video_o_tready (m_tready),
        .raw_video_o_tuser  (m_tuser),
        .raw_video_o_tlast  (m_tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference colour placement read from the pattern's name, row-major over the 2x2 tile.
    function automatic logic [9:0] model_px(input logic [1:0] pat, input logic en_m, input int row,
                                            input int col, input logic [9:0] rr, input logic [9:0] gg,
                                            input logic [9:0] bb);
        string s;
        byte   c;
        case (pat)
            2'd0:    s = "GBRG";
            2'd1:    s = "BGGR";
            2'd2:    s = "GRBG";
            default: s = "RGGB";
        endcase
        c = s[(row % 2) * 2 + (col % 2)];
        if (!en_m) return gg;
        if (c == "R") return rr;
        if (c == "B") return bb;
        return gg;
    endfunction

    task automatic send_px(input logic [9:0] rr, input logic [9:0] gg, input logic [9:0] bb,
                           input logic user, input logic last, input logic [9:0] exp_px,
                           input logic chk_lat);
        int   waited = 0;
        exp_t e;
        if (rand_valid) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_tdata  = {2'b00, rr, bb, gg};
        s_tuser  = user;
        s_tlast  = last;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: tready stayed 0, required 1 within 200 cycles");
        end else begin
            e.px = exp_px; e.user = user; e.last = last; e.chk_lat = chk_lat; e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin @(posedge clk); w++; end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        logic t0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #2;
            t0 = s_tready;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
            #1;
            if (rand_ready) check("tready_comb", {31'd0, s_tready}, {31'd0, t0});
        end
    end

    initial begin
        logic        prev_stall = 1'b0;
        logic [17:0] prev = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", {31'd0, m_tvalid}, 32'd1);
                    check("stall_stable", {14'd0, m_tdata, m_tuser, m_tlast}, {14'd0, prev});
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got tdata %0h, required no output", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", {16'd0, m_tdata}, {22'd0, e.px});
                        check("tuser", {31'd0, m_tuser}, {31'd0, e.user});
                        check("tlast", {31'd0, m_tlast}, {31'd0, e.last});
                        if (e.chk_lat) check("latency", cyc - e.acc_cyc, 32'd1);
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev       = {m_tdata, m_tuser, m_tlast};
            end
        end
    end

    initial begin
        #1ms;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        pattern = 2'd0; en = 1'b0; err_clr = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata",  {16'd0, m_tdata}, 32'd0);
        check("rst_tuser",  {31'd0, m_tuser}, 32'd0);
        check("rst_tlast",  {31'd0, m_tlast}, 32'd0);
        check("rst_err",    {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_tready", {31'd0, s_tready}, 32'd1);
        check("tkeep_tstrb", {28'd0, m_tkeep, m_tstrb}, 32'hF);

        // RGGB 4x2 constant colour frame
        pattern = 2'd3; en = 1'b1;
        for (int i = 0; i < 8; i++) send_px(10'h3FF, 10'h155, 10'h0AA, i == 0, i % 4 == 3, t1[i], 1'b0);

        // every pattern on a 2x2 frame
        for (int p = 0; p < 4; p++) begin
            pattern = 2'(p);
            for (int i = 0; i < 4; i++) send_px(10'd1, 10'd2, 10'd3, i == 0, i % 2 == 1, t2[p][i], 1'b0);
        end

        // bypass: G passes through with one cycle of latency
        pattern = 2'd3; en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
            send_px(r, g, b, i == 0, i % 4 == 3, g, 1'b1);
        end

        // pattern change mid-frame only takes effect at the next tuser
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) pattern = 2'd1;
            send_px(10'd1, 10'd2, 10'd3, i == 0, i % 4 == 3, t4a[i], 1'b0);
        end
        for (int i = 0; i < 8; i++) send_px(10'd1, 10'd2, 10'd3, i == 0, i % 4 == 3, t4b[i], 1'b0);
        wait_drain();
        check("err_short_lines", {31'd0, err}, 32'd0);

        // 64x8 GRBG frame under random valid/ready; lines exceed MAX_LINE_SIZE
        pattern = 2'd2; rand_valid = 1'b1; rand_ready = 1'b1;
        for (int row = 0; row < 8; row++)
            for (int col = 0; col < 64; col++) begin
                r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
                send_px(r, g, b, row == 0 && col == 0, col == 63, model_px(2'd2, 1'b1, row, col, r, g, b), 1'b0);
            end
        rand_valid = 1'b0; rand_ready = 1'b0; ready_level = 1'b1;
        wait_drain();
        check("err_long_lines", {31'd0, err}, 32'd1);
        pulse_clr();
        check("err_cleared", {31'd0, err}, 32'd0);

        // line-length boundary: exactly MAX beats is fine, MAX+1 without tlast flags
        pattern = 2'd3;
        for (int c = 0; c < 8; c++)
            send_px(10'd1, 10'd2, 10'd3, c == 0, c == 7, model_px(2'd3, 1'b1, 0, c, 10'd1, 10'd2, 10'd3), 1'b0);
        check("err_exact_max", {31'd0, err}, 32'd0);
        for (int c = 0; c < 9; c++) begin
            send_px(10'd1, 10'd2, 10'd3, 1'b0, 1'b0, model_px(2'd3, 1'b1, 1, c, 10'd1, 10'd2, 10'd3), 1'b0);
            if (c == 7) check("err_at_max", {31'd0, err}, 32'd0);
            if (c == 8) check("err_overflow", {31'd0, err}, 32'd1);
        end
        pulse_clr();
        check("err_clr_pulse", {31'd0, err}, 32'd0);
        ready_level = 1'b0;
        send_px(10'd1, 10'd2, 10'd3, 1'b0, 1'b0, model_px(2'd3, 1'b1, 1, 9, 10'd1, 10'd2, 10'd3), 1'b0);
        check("err_saturated", {31'd0, err}, 32'd1);
        send_px(10'd1, 10'd2, 10'd3, 1'b0, 1'b0, model_px(2'd3, 1'b1, 1, 10, 10'd1, 10'd2, 10'd3), 1'b0);

        // asynchronous reset while a beat is stalled at the output
        @(negedge clk);
        check("prereset_valid", {31'd0, m_tvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("arst_tdata",  {16'd0, m_tdata}, 32'd0);
        check("arst_tlast",  {31'd0, m_tlast}, 32'd0);
        check("arst_err",    {31'd0, err}, 32'd0);
        check("arst_tready", {31'd0, s_tready}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; ready_level = 1'b1;
        @(posedge clk); #1;
        check("rel2_tready", {31'd0, s_tready}, 32'd1);

        // before any tuser the frame registers are back at bypass
        send_px(10'd1, 10'd2, 10'd3, 1'b0, 1'b1, 10'd2, 1'b1);
        for (int i = 0; i < 4; i++) send_px(10'd1, 10'd2, 10'd3, i == 0, i % 2 == 1, t2[3][i], 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
